// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU's 16-bit memory port.
//   Low half of the byte address space (addr[15]=0) is a 16K-word synchronous RAM
//   indexed by addr[14:1]. High half (addr[15]=1) is an MMIO block holding an LED
//   register and a 16-bit compare timer with a level interrupt.
// Parameters:
//   RAM_INIT  hex file preloaded into the RAM; empty leaves contents unspecified
//   PRESCALE  timer tick period in clk cycles (1..65535)
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   i_mem_addr     byte address (bit 0 ignored, word access only)
//   i_mem_rd       read strobe
//   i_mem_wr       write strobe
//   i_mem_wrdata   write data
//   o_mem_rddata   registered read data (1-cycle latency, holds when idle)
//   o_mem_rdvalid  high for the cycle carrying the previous cycle's read response
//   o_leds         LED register contents
//   o_timer_irq    timer interrupt = flag AND irq_en
module mem_responder #(
    parameter string RAM_INIT = "",
    parameter int    PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_mem_addr,
    input  logic        i_mem_rd,
    input  logic        i_mem_wr,
    input  logic [15:0] i_mem_wrdata,
    output logic [15:0] o_mem_rddata,
    output logic        o_mem_rdvalid,
    output logic [15:0] o_leds,
    output logic        o_timer_irq
);

    localparam logic [13:0] LED_IDX    = 14'd0;
    localparam logic [13:0] TCOUNT_IDX = 14'd1;
    localparam logic [13:0] TCMP_IDX   = 14'd2;
    localparam logic [13:0] TCTRL_IDX  = 14'd3;
    localparam logic [13:0] TSTAT_IDX  = 14'd4;
    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    logic [15:0] ram_r [0:16383];

    logic [15:0] rddata_r;
    logic        rdvalid_r;
    logic [15:0] led_r;
    logic [15:0] tcount_r;
    logic [15:0] tcmp_r;
    logic        tctrl_en_r;
    logic        tctrl_irqen_r;
    logic        flag_r;
    logic [15:0] presc_r;

    logic [13:0] word_idx_s;
    logic        sel_mmio_s;
    logic        addr_lsb_unused_s;
    logic        ram_we_s;
    logic        led_we_s;
    logic        tcmp_we_s;
    logic        tctrl_we_s;
    logic        tstat_we_s;
    logic [15:0] mmio_rd_s;
    logic [15:0] ram_rd_s;
    logic        tick_s;
    logic        match_s;
    logic [15:0] presc_nxt_s;
    logic [15:0] tcount_nxt_s;
    logic        flag_nxt_s;

    assign word_idx_s        = i_mem_addr[14:1];
    assign sel_mmio_s        = i_mem_addr[15];
    assign addr_lsb_unused_s = i_mem_addr[0];
    assign ram_rd_s          = ram_r[word_idx_s];

    // Write-enable decode; RAM writes are suppressed while reset is asserted so an
    // access interrupted by reset never lands.
    always_comb begin
        ram_we_s   = 1'b0;
        led_we_s   = 1'b0;
        tcmp_we_s  = 1'b0;
        tctrl_we_s = 1'b0;
        tstat_we_s = 1'b0;
        if (i_mem_wr && sel_mmio_s) begin
            case (word_idx_s)
                LED_IDX:   led_we_s   = 1'b1;
                TCMP_IDX:  tcmp_we_s  = 1'b1;
                TCTRL_IDX: tctrl_we_s = 1'b1;
                TSTAT_IDX: tstat_we_s = 1'b1;
                default:   led_we_s   = 1'b0;
            endcase
        end else begin
            ram_we_s = i_mem_wr && reset;
        end
    end

    // MMIO read mux from pre-edge register state (gives read-before-write).
    always_comb begin
        mmio_rd_s = 16'h0000;
        case (word_idx_s)
            LED_IDX:    mmio_rd_s = led_r;
            TCOUNT_IDX: mmio_rd_s = tcount_r;
            TCMP_IDX:   mmio_rd_s = tcmp_r;
            TCTRL_IDX:  mmio_rd_s = {13'd0, tctrl_irqen_r, 1'b0, tctrl_en_r};
            TSTAT_IDX:  mmio_rd_s = {15'd0, flag_r};
            default:    mmio_rd_s = 16'h0000;
        endcase
    end

    // Timer next-state: prescaler tick, compare/reset of TCOUNT, flag set/clear.
    // A TCTRL clear overrides the tick update; a flag set beats a TSTAT clear.
    always_comb begin
        tick_s       = tctrl_en_r && (presc_r == PRESC_LAST);
        match_s      = tick_s && (tcount_r == tcmp_r);
        presc_nxt_s  = presc_r;
        tcount_nxt_s = tcount_r;
        if (tctrl_we_s && i_mem_wrdata[1]) begin
            presc_nxt_s  = 16'h0000;
            tcount_nxt_s = 16'h0000;
        end else if (tctrl_en_r) begin
            presc_nxt_s  = tick_s ? 16'h0000 : (presc_r + 16'd1);
            if (tick_s) begin
                tcount_nxt_s = match_s ? 16'h0000 : (tcount_r + 16'd1);
            end else begin
                tcount_nxt_s = tcount_r;
            end
        end else begin
            presc_nxt_s  = presc_r;
            tcount_nxt_s = tcount_r;
        end
        if (match_s) begin
            flag_nxt_s = 1'b1;
        end else if (tstat_we_s && i_mem_wrdata[0]) begin
            flag_nxt_s = 1'b0;
        end else begin
            flag_nxt_s = flag_r;
        end
    end

    // RAM array; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[word_idx_s] <= i_mem_wrdata;
        end
    end

    // Read response register; data holds between reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rddata_r  <= 16'h0000;
            rdvalid_r <= 1'b0;
        end else begin
            rdvalid_r <= i_mem_rd;
            if (i_mem_rd) begin
                rddata_r <= sel_mmio_s ? mmio_rd_s : ram_rd_s;
            end
        end
    end

    // MMIO and timer state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_r         <= 16'h0000;
            tcount_r      <= 16'h0000;
            tcmp_r        <= 16'hFFFF;
            tctrl_en_r    <= 1'b0;
            tctrl_irqen_r <= 1'b0;
            flag_r        <= 1'b0;
            presc_r       <= 16'h0000;
        end else begin
            presc_r  <= presc_nxt_s;
            tcount_r <= tcount_nxt_s;
            flag_r   <= flag_nxt_s;
            if (led_we_s) begin
                led_r <= i_mem_wrdata;
            end
            if (tcmp_we_s) begin
                tcmp_r <= i_mem_wrdata;
            end
            if (tctrl_we_s) begin
                tctrl_en_r    <= i_mem_wrdata[0];
                tctrl_irqen_r <= i_mem_wrdata[2];
            end
        end
    end

    assign o_mem_rddata  = rddata_r;
    assign o_mem_rdvalid = rdvalid_r;
    assign o_leds        = led_r;
    assign o_timer_irq   = flag_r & tctrl_irqen_r;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder. A behavioural model (associative RAM plus
// timer registers updated with plain arithmetic) predicts every response; a second
// instance with PRESCALE=3 checks the prescaler period.
module tb_mem_responder;

    localparam int P_MAIN = 1;
    localparam int P_SLOW = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] i_mem_addr;
    logic        i_mem_rd;
    logic        i_mem_wr;
    logic [15:0] i_mem_wrdata;
    logic [15:0] o_mem_rddata;
    logic        o_mem_rdvalid;
    logic [15:0] o_leds;
    logic        o_timer_irq;
    logic [15:0] s_rddata;
    logic        s_rdvalid;
    logic [15:0] s_leds;
    logic        s_irq;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic [15:0] m_ram [int];
    logic [15:0] m_led, m_count, m_cmp;
    bit          m_en, m_irqen, m_flag;
    int          m_presc;
    logic [15:0] exp_rd;
    bit          exp_valid, exp_known;

    always #5 clk = ~clk;

    mem_responder #(.RAM_INIT(""), .PRESCALE(P_MAIN)) dut (
        .clk(clk), .reset(reset), .i_mem_addr(i_mem_addr), .i_mem_rd(i_mem_rd),
        .i_mem_wr(i_mem_wr), .i_mem_wrdata(i_mem_wrdata), .o_mem_rddata(o_mem_rddata),
        .o_mem_rdvalid(o_mem_rdvalid), .o_leds(o_leds), .o_timer_irq(o_timer_irq)
    );

    mem_responder #(.RAM_INIT(""), .PRESCALE(P_SLOW)) dut_slow (
        .clk(clk), .reset(reset), .i_mem_addr(i_mem_addr), .i_mem_rd(i_mem_rd),
        .i_mem_wr(i_mem_wr), .i_mem_wrdata(i_mem_wrdata), .o_mem_rddata(s_rddata),
        .o_mem_rdvalid(s_rdvalid), .o_leds(s_leds), .o_timer_irq(s_irq)
    );

    task automatic model_reset();
        m_led = 16'h0000; m_count = 16'h0000; m_cmp = 16'hFFFF;
        m_en = 1'b0; m_irqen = 1'b0; m_flag = 1'b0; m_presc = 0;
        exp_rd = 16'h0000; exp_valid = 1'b0; exp_known = 1'b1;
    endtask

    // One clock edge of bus activity applied to the model.
    task automatic model_edge(input logic rd, input logic wr, input logic [15:0] a,
                              input logic [15:0] d);
        int          w;
        bit          mmio, tick, match, n_flag;
        logic [15:0] n_count;
        int          n_presc;
        w = int'(a[14:1]);
        mmio = a[15];
        exp_valid = rd;
        if (rd) begin
            exp_known = 1'b1;
            if (!mmio) begin
                if (m_ram.exists(w)) exp_rd = m_ram[w];
                else exp_known = 1'b0;
            end else begin
                case (w)
                    0: exp_rd = m_led;
                    1: exp_rd = m_count;
                    2: exp_rd = m_cmp;
                    3: exp_rd = {13'd0, m_irqen, 1'b0, m_en};
                    4: exp_rd = {15'd0, m_flag};
                    default: exp_rd = 16'h0000;
                endcase
            end
        end
        tick = m_en && (m_presc == P_MAIN - 1);
        match = tick && (m_count == m_cmp);
        n_count = m_count; n_presc = m_presc; n_flag = m_flag;
        if (m_en) begin
            n_presc = tick ? 0 : m_presc + 1;
            if (tick) n_count = match ? 16'h0000 : m_count + 16'h0001;
        end
        if (wr && mmio && w == 4 && d[0]) n_flag = 1'b0;
        if (match) n_flag = 1'b1;
        if (wr && !mmio) m_ram[w] = d;
        if (wr && mmio) begin
            if (w == 0) m_led = d;
            if (w == 2) m_cmp = d;
            if (w == 3) begin
                m_en = d[0]; m_irqen = d[2];
                if (d[1]) begin n_count = 16'h0000; n_presc = 0; end
            end
        end
        m_count = n_count; m_presc = n_presc; m_flag = n_flag;
    endtask

    // Drive one bus cycle, advance the model, sample #1 after the edge.
    task automatic bus(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] d);
        i_mem_rd = rd; i_mem_wr = wr; i_mem_addr = a; i_mem_wrdata = d;
        model_edge(rd, wr, a, d);
        @(posedge clk); #1;
        i_mem_rd = 1'b0; i_mem_wr = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] rst_vals [5];
        rst_vals[0] = 16'h0000; rst_vals[1] = 16'h0000; rst_vals[2] = 16'hFFFF;
        rst_vals[3] = 16'h0000; rst_vals[4] = 16'h0000;
        reset = 1'b0;
        #1;
        tests_run++; if (o_mem_rddata !== 16'h0000 || o_mem_rdvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_rd: got %h/%b want 0000/0", o_mem_rddata, o_mem_rdvalid); end
        tests_run++; if (o_leds !== 16'h0000 || o_timer_irq !== 1'b0) begin tests_failed++; $display("FAIL reset_out: got leds=%h irq=%b want 0000/0", o_leds, o_timer_irq); end
        repeat (2) @(posedge clk);
        #1; reset = 1'b1;
        model_reset();
        for (int w = 0; w < 5; w++) begin
            bus(1'b1, 1'b0, 16'h8000 | 16'(w << 1), 16'h0000);
            tests_run++; if (o_mem_rddata !== rst_vals[w] || o_mem_rdvalid !== 1'b1) begin tests_failed++; $display("FAIL reset_reg%0d: got %h/%b want %h/1", w, o_mem_rddata, o_mem_rdvalid, rst_vals[w]); end
        end
    endtask

    task automatic test_ram();
        logic [15:0] addrs [$];
        logic [15:0] a;
        bus(1'b0, 1'b1, 16'h0010, 16'h1234);
        bus(1'b1, 1'b0, 16'h0010, 16'h0000);
        tests_run++; if (o_mem_rddata !== 16'h1234 || o_mem_rdvalid !== 1'b1) begin tests_failed++; $display("FAIL ram_basic: got %h/%b want 1234/1", o_mem_rddata, o_mem_rdvalid); end
        bus(1'b0, 1'b0, 16'h0000, 16'h0000);
        tests_run++; if (o_mem_rddata !== 16'h1234 || o_mem_rdvalid !== 1'b0) begin tests_failed++; $display("FAIL ram_hold: got %h/%b want 1234/0", o_mem_rddata, o_mem_rdvalid); end
        bus(1'b1, 1'b0, 16'h0011, 16'h0000);
        tests_run++; if (o_mem_rddata !== 16'h1234) begin tests_failed++; $display("FAIL ram_odd_addr: got %h want 1234", o_mem_rddata); end
        for (int i = 0; i < 32; i++) begin
            a = {1'b0, 14'($urandom), 1'($urandom)};
            addrs.push_back(a);
            bus(1'b0, 1'b1, a, 16'($urandom));
        end
        for (int i = 0; i < 48; i++) begin
            a = addrs[$urandom_range(0, addrs.size() - 1)];
            bus(1'b1, 1'b0, a, 16'h0000);
            tests_run++; if (o_mem_rdvalid !== 1'b1 || o_mem_rddata !== exp_rd) begin tests_failed++; $display("FAIL ram_rand @%h: got %h/%b want %h/1", a, o_mem_rddata, o_mem_rdvalid, exp_rd); end
        end
    endtask

    task automatic test_rbw();
        bus(1'b0, 1'b1, 16'h0020, 16'hAAAA);
        bus(1'b1, 1'b1, 16'h0020, 16'h5555);
        tests_run++; if (o_mem_rddata !== 16'hAAAA) begin tests_failed++; $display("FAIL rbw_ram_old: got %h want AAAA", o_mem_rddata); end
        bus(1'b1, 1'b0, 16'h0020, 16'h0000);
        tests_run++; if (o_mem_rddata !== 16'h5555) begin tests_failed++; $display("FAIL rbw_ram_new: got %h want 5555", o_mem_rddata); end
        bus(1'b0, 1'b1, 16'h8000, 16'h1111);
        bus(1'b1, 1'b1, 16'h8000, 16'h2222);
        tests_run++; if (o_mem_rddata !== 16'h1111 || o_leds !== 16'h2222) begin tests_failed++; $display("FAIL rbw_led: got rd=%h leds=%h want 1111/2222", o_mem_rddata, o_leds); end
    endtask

    task automatic test_led_unmapped();
        logic [15:0] a;
        bus(1'b0, 1'b1, 16'h8000, 16'hBEEF);
        tests_run++; if (o_leds !== 16'hBEEF) begin tests_failed++; $display("FAIL led_write: got %h want BEEF", o_leds); end
        bus(1'b0, 1'b1, 16'h800A, 16'h1234);
        bus(1'b1, 1'b0, 16'h800A, 16'h0000);
        tests_run++; if (o_mem_rddata !== 16'h0000 || o_leds !== 16'hBEEF) begin tests_failed++; $display("FAIL unmapped_800A: got rd=%h leds=%h want 0000/BEEF", o_mem_rddata, o_leds); end
        bus(1'b0, 1'b1, 16'h8002, 16'h5A5A);
        bus(1'b1, 1'b0, 16'h8002, 16'h0000);
        tests_run++; if (o_mem_rddata !== 16'h0000) begin tests_failed++; $display("FAIL tcount_ro: got %h want 0000", o_mem_rddata); end
        for (int i = 0; i < 8; i++) begin
            a = {1'b1, 14'($urandom_range(5, 16383)), 1'($urandom)};
            bus(1'b0, 1'b1, a, 16'($urandom));
            bus(1'b1, 1'b0, a, 16'h0000);
            tests_run++; if (o_mem_rddata !== 16'h0000 || o_leds !== 16'hBEEF) begin tests_failed++; $display("FAIL unmapped_rand @%h: got rd=%h leds=%h want 0000/BEEF", a, o_mem_rddata, o_leds); end
        end
    endtask

    task automatic test_timer_match();
        int guard;
        bus(1'b0, 1'b1, 16'h8004, 16'h0003);
        bus(1'b0, 1'b1, 16'h8006, 16'h0005);
        for (int k = 1; k <= 4; k++) begin
            bus(1'b0, 1'b0, 16'h0000, 16'h0000);
            tests_run++; if (o_timer_irq !== (k == 4)) begin tests_failed++; $display("FAIL match_edge%0d: got irq=%b want %b", k, o_timer_irq, (k == 4)); end
        end
        bus(1'b1, 1'b0, 16'h8002, 16'h0000);
        tests_run++; if (o_mem_rddata !== 16'h0000) begin tests_failed++; $display("FAIL match_tcount: got %h want 0000", o_mem_rddata); end
        bus(1'b1, 1'b0, 16'h8008, 16'h0000);
        tests_run++; if (o_mem_rddata !== 16'h0001) begin tests_failed++; $display("FAIL match_tstat: got %h want 0001", o_mem_rddata); end
        guard = 0;
        while (m_count != m_cmp && guard < 10) begin bus(1'b0, 1'b0, 16'h0000, 16'h0000); guard++; end
        bus(1'b0, 1'b1, 16'h8008, 16'h0001);
        tests_run++; if (o_timer_irq !== 1'b1) begin tests_failed++; $display("FAIL set_beats_clear: got irq=%b want 1", o_timer_irq); end
        bus(1'b0, 1'b1, 16'h8008, 16'h0001);
        tests_run++; if (o_timer_irq !== 1'b0) begin tests_failed++; $display("FAIL tstat_clear: got irq=%b want 0", o_timer_irq); end
        guard = 0;
        while (!m_flag && guard < 10) begin bus(1'b0, 1'b0, 16'h0000, 16'h0000); guard++; end
        bus(1'b0, 1'b1, 16'h8006, 16'h0001);
        tests_run++; if (o_timer_irq !== 1'b0) begin tests_failed++; $display("FAIL irq_mask: got irq=%b want 0", o_timer_irq); end
        bus(1'b1, 1'b0, 16'h8008, 16'h0000);
        tests_run++; if (o_mem_rddata !== 16'h0001) begin tests_failed++; $display("FAIL mask_flag: got %h want 0001", o_mem_rddata); end
        bus(1'b0, 1'b1, 16'h8006, 16'h0005);
        tests_run++; if (o_timer_irq !== 1'b1) begin tests_failed++; $display("FAIL irq_unmask: got irq=%b want 1", o_timer_irq); end
    endtask

    task automatic test_random_mixed();
        logic [15:0] a, d;
        logic        rd, wr;
        int          w;
        for (int i = 0; i < 300; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 4) begin
                a = {9'd0, 6'($urandom), 1'($urandom)};
                d = 16'($urandom);
            end else begin
                w = $urandom_range(0, 6);
                a = 16'h8000 | 16'(w << 1) | 16'($urandom_range(0, 1));
                if (w == 2) d = 16'($urandom_range(0, 6));
                else if (w == 3) d = 16'($urandom_range(0, 7));
                else d = 16'($urandom);
            end
            bus(rd, wr, a, d);
            tests_run++;
            if (o_mem_rdvalid !== exp_valid || (exp_known && o_mem_rddata !== exp_rd) ||
                o_leds !== m_led || o_timer_irq !== (m_flag & m_irqen)) begin
                tests_failed++;
                $display("FAIL mixed%0d @%h rd=%b wr=%b: got rd=%h/%b leds=%h irq=%b want %h/%b %h %b",
                         i, a, rd, wr, o_mem_rddata, o_mem_rdvalid, o_leds, o_timer_irq,
                         exp_rd, exp_valid, m_led, m_flag & m_irqen);
            end
        end
    endtask

    task automatic test_clear_wrap();
        bus(1'b0, 1'b1, 16'h8006, 16'h0002);
        bus(1'b0, 1'b1, 16'h8004, 16'hFFFF);
        bus(1'b0, 1'b1, 16'h8008, 16'h0001);
        bus(1'b0, 1'b1, 16'h8006, 16'h0001);
        for (int i = 0; i < 65534; i++) bus(1'b0, 1'b0, 16'h0000, 16'h0000);
        bus(1'b1, 1'b0, 16'h8002, 16'h0000);
        tests_run++; if (o_mem_rddata !== 16'hFFFE) begin tests_failed++; $display("FAIL wrap_pre: got %h want FFFE", o_mem_rddata); end
        bus(1'b1, 1'b0, 16'h8008, 16'h0000);
        tests_run++; if (o_mem_rddata !== 16'h0000) begin tests_failed++; $display("FAIL wrap_flag_pre: got %h want 0000", o_mem_rddata); end
        bus(1'b1, 1'b0, 16'h8002, 16'h0000);
        tests_run++; if (o_mem_rddata !== 16'h0000) begin tests_failed++; $display("FAIL wrap_zero: got %h want 0000", o_mem_rddata); end
        bus(1'b1, 1'b0, 16'h8008, 16'h0000);
        tests_run++; if (o_mem_rddata !== 16'h0001 || o_timer_irq !== 1'b0) begin tests_failed++; $display("FAIL wrap_flag: got %h irq=%b want 0001/0", o_mem_rddata, o_timer_irq); end
        bus(1'b0, 1'b1, 16'h8006, 16'h0003);
        bus(1'b1, 1'b0, 16'h8002, 16'h0000);
        tests_run++; if (o_mem_rddata !== 16'h0000) begin tests_failed++; $display("FAIL clear_zero: got %h want 0000", o_mem_rddata); end
        bus(1'b1, 1'b0, 16'h8002, 16'h0000);
        tests_run++; if (o_mem_rddata !== 16'h0001) begin tests_failed++; $display("FAIL clear_running: got %h want 0001", o_mem_rddata); end
        bus(1'b1, 1'b0, 16'h8006, 16'h0000);
        tests_run++; if (o_mem_rddata !== 16'h0001) begin tests_failed++; $display("FAIL clear_tctrl: got %h want 0001", o_mem_rddata); end
    endtask

    task automatic test_async_reset();
        bus(1'b0, 1'b1, 16'h0030, 16'h7777);
        bus(1'b0, 1'b1, 16'h8000, 16'h00FF);
        bus(1'b0, 1'b1, 16'h8004, 16'h0000);
        bus(1'b0, 1'b1, 16'h8006, 16'h0005);
        bus(1'b1, 1'b0, 16'h0030, 16'h0000);
        tests_run++; if (o_timer_irq !== 1'b1 || o_mem_rddata !== 16'h7777) begin tests_failed++; $display("FAIL pre_reset: got irq=%b rd=%h want 1/7777", o_timer_irq, o_mem_rddata); end
        i_mem_rd = 1'b1; i_mem_wr = 1'b1; i_mem_addr = 16'h0030; i_mem_wrdata = 16'hDEAD;
        #2; reset = 1'b0; #1;
        tests_run++; if (o_mem_rddata !== 16'h0000 || o_mem_rdvalid !== 1'b0 || o_leds !== 16'h0000 || o_timer_irq !== 1'b0) begin tests_failed++; $display("FAIL async_reset: got rd=%h/%b leds=%h irq=%b want 0000/0 0000 0", o_mem_rddata, o_mem_rdvalid, o_leds, o_timer_irq); end
        @(posedge clk); #1;
        tests_run++; if (o_mem_rdvalid !== 1'b0 || o_leds !== 16'h0000) begin tests_failed++; $display("FAIL reset_held: got valid=%b leds=%h want 0/0000", o_mem_rdvalid, o_leds); end
        #3; reset = 1'b1; i_mem_rd = 1'b0; i_mem_wr = 1'b0;
        model_reset();
        @(posedge clk); #1;
        bus(1'b1, 1'b0, 16'h0030, 16'h0000);
        tests_run++; if (o_mem_rddata !== 16'h7777) begin tests_failed++; $display("FAIL ram_retained: got %h want 7777", o_mem_rddata); end
        bus(1'b1, 1'b0, 16'h8004, 16'h0000);
        tests_run++; if (o_mem_rddata !== 16'hFFFF) begin tests_failed++; $display("FAIL post_tcmp: got %h want FFFF", o_mem_rddata); end
        bus(1'b1, 1'b0, 16'h8006, 16'h0000);
        tests_run++; if (o_mem_rddata !== 16'h0000) begin tests_failed++; $display("FAIL post_tctrl: got %h want 0000", o_mem_rddata); end
        bus(1'b1, 1'b0, 16'h8008, 16'h0000);
        tests_run++; if (o_mem_rddata !== 16'h0000) begin tests_failed++; $display("FAIL post_tstat: got %h want 0000", o_mem_rddata); end
    endtask

    task automatic test_prescale();
        int n;
        reset = 1'b0; #4; reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        bus(1'b0, 1'b1, 16'h8004, 16'h0002);
        bus(1'b0, 1'b1, 16'h8006, 16'h0005);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            bus(1'b0, 1'b0, 16'h0000, 16'h0000);
            n++;
            if (s_irq === 1'b1) break;
        end
        tests_run++; if (n !== 9 || s_irq !== 1'b1) begin tests_failed++; $display("FAIL prescale3_edge: got edge %0d irq=%b want 9/1", n, s_irq); end
        tests_run++; if (o_timer_irq !== (m_flag & m_irqen)) begin tests_failed++; $display("FAIL prescale1_irq: got %b want %b", o_timer_irq, m_flag & m_irqen); end
    endtask

    initial begin
        i_mem_rd = 1'b0; i_mem_wr = 1'b0; i_mem_addr = 16'h0000; i_mem_wrdata = 16'h0000;
        reset = 1'b0;
        model_reset();
        test_reset();
        test_ram();
        test_rbw();
        test_led_unmapped();
        test_timer_match();
        test_random_mixed();
        test_clear_wrap();
        test_async_reset();
        test_prescale();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the processor's 16-bit memory port: it accepts byte addresses, read strobes and write strobes from the CPU and returns registered read data. The low half of the address space is a synchronous word RAM holding instructions and data. The high half is a small memory-mapped peripheral block: an LED register and a 16-bit compare timer with an interrupt output. It sits directly below the CPU in the processor top level.

## Interface
- RAM_INIT, "" : hex file loaded into RAM at elaboration; empty means RAM contents are unspecified.
- PRESCALE, 1 : timer tick period in clk cycles; legal range 1..65535.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- i_mem_addr  in  16  byte address from the CPU; bit 0 is ignored (word access only).
- i_mem_rd  in  1  read strobe.
- i_mem_wr  in  1  write strobe.
- i_mem_wrdata  in  16  write data.
- o_mem_rddata  out  16  registered read data.
- o_mem_rdvalid  out  1  high for the cycle in which o_mem_rddata holds the response to the previous cycle's read.
- o_leds  out  16  LED register contents.
- o_timer_irq  out  1  timer interrupt, level; equals TSTAT.flag AND TCTRL.irq_en.

## Operation
- Decode: i_mem_addr[15]=0 selects RAM. The RAM is 16K words, indexed by i_mem_addr[14:1]. i_mem_addr[15]=1 selects MMIO.
- MMIO map (byte addresses):
  - 0x8000 LED (R/W).
  - 0x8002 TCOUNT (R; writes ignored).
  - 0x8004 TCMP (R/W).
  - 0x8006 TCTRL (R/W). Bit0 enable, bit1 clear, bit2 irq_en. Bit1 is self-clearing and always reads 0. Bits [15:3] read 0.
  - 0x8008 TSTAT. Bit0 flag. Writing 1 to bit0 clears the flag; writing 0 has no effect.
  - Every other MMIO address reads 0x0000 and ignores writes.
- Timer:
  - A prescaler counts clk cycles while enable=1. On every PRESCALE-th cycle it produces a tick.
  - On a tick, if TCOUNT==TCMP, TCOUNT becomes 0 and flag is set. Otherwise TCOUNT increments, wrapping 0xFFFF to 0.
  - When enable=0, both the prescaler and TCOUNT hold.
  - Writing TCTRL with bit1=1 zeroes TCOUNT and the prescaler in that same edge. That write's bit0 and bit2 still take effect.
  - If a flag set and a TSTAT clear occur on the same edge, the set wins.
- Read and write together to the same address: the read returns the old value (read-before-write). This applies to both RAM and MMIO.
- When i_mem_rd=0, o_mem_rddata holds its last value and o_mem_rdvalid=0.
- Reset (reset=0, asynchronous) clears:
  - o_mem_rddata=0x0000 and o_mem_rdvalid=0;
  - LED=0x0000 and TCOUNT=0x0000;
  - TCMP=0xFFFF, TCTRL=0, flag=0, prescaler=0;
  - therefore o_leds=0 and o_timer_irq=0.
- RAM contents are not affected by reset. Reset asserted mid-access aborts the access; no partial write occurs after reset is released.

## Timing
- Read latency is 1 cycle. Address and i_mem_rd are sampled at edge N. o_mem_rddata and o_mem_rdvalid are valid after edge N until edge N+1.
- Back-to-back reads on consecutive cycles are supported at full throughput.
- Writes commit at the sampling edge. A read of the same address on the next cycle returns the new data.
- A TCOUNT read returns the value before that edge's tick update.
- The flag rises on the edge of the matching tick. o_timer_irq follows combinationally from registered state, with no extra cycle.
- With PRESCALE=1, a tick occurs every cycle while enabled. From enable=1 and TCOUNT=0, the flag sets on the (TCMP+1)-th enabled edge.
- No combinational path exists from any i_mem_* input to o_mem_rddata.

## Test plan
- Reset then RAM read/write: write 0x1234 to 0x0010, read 0x0010 on the next cycle -> o_mem_rddata=0x1234 with o_mem_rdvalid=1 exactly one cycle after the read strobe. Read 0x0011 -> same word.
- Read-before-write: hold 0xAAAA at 0x0020; in one cycle read and write 0x5555 to 0x0020 -> response 0xAAAA; next read returns 0x5555.
- LED and unmapped space: write 0xBEEF to 0x8000 -> o_leds=0xBEEF after the edge. Write to 0x800A, then read it back -> 0x0000, and o_leds is unchanged.
- Timer match with PRESCALE=1:
  - Setup: TCMP=3, TCTRL=0b101.
  - Flag and o_timer_irq rise on the 4th enabled edge; TCOUNT then reads 0.
  - Writing 1 to TSTAT drops o_timer_irq.
  - If that clear lands on a match edge, the flag stays 1.
- Timer clear and wrap: with TCMP=0xFFFF and TCOUNT=0xFFFE, TCOUNT wraps to 0 with the flag set. Writing TCTRL=0b011 zeroes TCOUNT, keeps the timer enabled, and TCTRL reads 0b001.
- Asynchronous reset mid-operation: drop reset between clock edges during a write burst and timer run -> all outputs and registers reach their reset values immediately. RAM words written before reset are retained.
